writeback_unit: RTL and testbench

//  Write-side producer for the CPU register file. Collects results from the ALU and load/memory paths,

---
 rtl/wb_pkg.sv | 17 +
 rtl/load_formatter.sv | 31 +++
 rtl/writeback_unit.sv | 140 ++++++++++++++
 tb/tb_writeback_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback unit.
//   LOAD_*     : RISC-V load funct3 encodings understood by the load formatter
//   wb_entry_t : one queued register-file write (destination index + data)
package wb_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data extractor.
//   mem_word    : raw aligned 32-bit memory word
//   mem_funct3  : load type (LB/LH/LW/LBU/LHU)
//   mem_addr_lo : byte address [1:0]; bit 0 is ignored for halfword loads
//   result      : extended 32-bit value headed for the register file
// Unknown funct3 values pass the whole word through, same as LW.
module load_formatter
  import wb_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[{mem_addr_lo, 3'b000} +: 8];
    half_sel = mem_addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    case (mem_funct3)
      LOAD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: result = {24'd0, byte_sel};
      LOAD_LH:  result = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: result = {16'd0, half_sel};
      default:  result = mem_word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write producer. Merges load and ALU results into a small
// in-order FIFO and drains one entry per clock into the register file.
// Optional forwarding lookup is built when WB_FWD_EN is defined.
//   clock, reset_n        : core clock, async active-low reset
//   mem_valid/ready/...   : load result handshake and payload (formatted here)
//   alu_valid/ready/...   : ALU result handshake and payload
//   rd, data, reg_write   : register-file write port (head of queue)
//   pending               : one-hot OR of queued destinations (x0 never set)
//   fwd_rs*/fwd_hit*/fwd_data* : youngest-match lookup (WB_FWD_EN only)
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_word,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
`ifdef WB_FWD_EN
  input  logic [4:0]  fwd_rs1,
  input  logic [4:0]  fwd_rs2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
`endif
  output logic [4:0]  rd,
  output logic [31:0] data,
  output logic        reg_write,
  output logic [31:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         entries_q [DEPTH];
  wb_entry_t         entries_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     free;
  logic              pop, mem_push, alu_push;
  logic [31:0]       mem_fmt;
  logic [PW-1:0]     off;

  load_formatter u_fmt (
    .mem_word    (mem_word),
    .mem_funct3  (mem_funct3),
    .mem_addr_lo (mem_addr_lo),
    .result      (mem_fmt)
  );

  // The register file always accepts, so the head leaves on every edge the
  // queue is non-empty; that slot is reusable in the same cycle.
  always_comb begin
    pop       = (count_q != '0);
    free      = CW'(DEPTH) - count_q + CW'(pop);
    mem_ready = (free != '0);
    alu_ready = (free >= (CW'(mem_valid) + CW'(1)));
    // x0 writes complete the handshake but are dropped here.
    mem_push  = mem_valid && mem_ready && (mem_rd != 5'd0);
    alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);

    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    // Load goes in first: it belongs to the older instruction.
    if (mem_push) begin
      entries_d[wr_ptr_d] = '{rd: mem_rd, data: mem_fmt};
      wr_ptr_d            = wr_ptr_d + PW'(1);
    end
    if (alu_push) begin
      entries_d[wr_ptr_d] = '{rd: alu_rd, data: alu_data};
      wr_ptr_d            = wr_ptr_d + PW'(1);
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q - CW'(pop) + CW'(mem_push) + CW'(alu_push);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  // Write port and pending mask come straight from queue state, so they only
  // move on posedge (or at reset, since count_q clears asynchronously).
  always_comb begin
    reg_write = pop;
    rd        = pop ? entries_q[rd_ptr_q].rd   : 5'd0;
    data      = pop ? entries_q[rd_ptr_q].data : 32'd0;
    pending   = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;  // age of slot i relative to head
      if (CW'(off) < count_q) pending[entries_q[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest; the last match wins so the youngest value is used.
  logic [PW-1:0] fidx;
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    fidx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (fwd_rs1 != 5'd0 && entries_q[fidx].rd == fwd_rs1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = entries_q[fidx].data;
        end
        if (fwd_rs2 != 5'd0 && entries_q[fidx].rd == fwd_rs2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = entries_q[fidx].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a scoreboard of expected writes.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0, alu_valid = 1'b0;
  logic        mem_ready, alu_ready;
  logic [4:0]  mem_rd = '0, alu_rd = '0;
  logic [31:0] mem_word = '0, alu_data = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        reg_write;
  logic [31:0] pending;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1 = '0, fwd_rs2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_word(mem_word), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data),
`ifdef WB_FWD_EN
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1),
    .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .rd(rd), .data(data), .reg_write(reg_write), .pending(pending)
  );

  always #5 clock = ~clock;

  int        n_assert = 0;
  int        n_fail = 0;
  int        mcount = 0;   // expected queue occupancy
  wb_entry_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register-file side: every write must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (reg_write) begin
        if (sb.size() == 0) begin
          chk("write_while_sb_empty", 32'(rd), 32'hFFFF_FFFF);
        end else begin
          wb_entry_t e;
          e = sb.pop_front();
          chk("wr_rd", 32'(rd), 32'(e.rd));
          chk("wr_data", data, e.data);
        end
      end else begin
        chk("idle_rd", 32'(rd), 32'd0);
        chk("idle_data", data, 32'd0);
      end
    end
  end

  // One cycle of stimulus; called just after a posedge, returns just after the next.
  task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] mword,
                      input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] mexp,
                      input logic av, input logic [4:0] ard, input logic [31:0] adata);
    int   pop, free;
    logic er_m, er_a;
    mem_valid = mv; mem_rd = mrd; mem_word = mword; mem_funct3 = f3; mem_addr_lo = alo;
    alu_valid = av; alu_rd = ard; alu_data = adata;
    pop  = (mcount != 0) ? 1 : 0;
    free = DEPTH - mcount + pop;
    er_m = (free >= 1);
    er_a = (free >= 1 + int'(mv));
    @(negedge clock);
    chk("mem_ready", 32'(mem_ready), 32'(er_m));
    chk("alu_ready", 32'(alu_ready), 32'(er_a));
    if (mv && er_m && mrd != 5'd0) begin sb.push_back('{rd: mrd, data: mexp}); mcount++; end
    if (av && er_a && ard != 5'd0) begin sb.push_back('{rd: ard, data: adata}); mcount++; end
    mcount -= pop;
    @(posedge clock); #1;
    mem_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] d);
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b1, r, d);
  endtask

  task automatic load(input logic [4:0] r, input logic [31:0] w, input logic [2:0] f3,
                      input logic [1:0] alo, input logic [31:0] exp);
    step(1'b1, r, w, f3, alo, exp, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset mid-stream with three entries queued (x2, x3, x4 after x1 drains)
    step(1'b1, 5'd1, 32'h11, LOAD_LW, 2'd0, 32'h11, 1'b1, 5'd2, 32'h22);
    step(1'b1, 5'd3, 32'h33, LOAD_LW, 2'd0, 32'h33, 1'b1, 5'd4, 32'h44);
    chk("pre_rst_pending", pending, 32'h0000_001C);
    chk("pre_rst_reg_write", 32'(reg_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_reg_write", 32'(reg_write), 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_rd", 32'(rd), 32'd0);
    sb.delete();
    mcount = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(); idle(); idle();

    // Single ALU write into an empty queue
    alu(5'd5, 32'hDEAD_BEEF);
    chk("alu_wr_reg_write", 32'(reg_write), 32'd1);
    chk("alu_wr_pending", pending, 32'h0000_0020);
    idle();
    chk("alu_after_reg_write", 32'(reg_write), 32'd0);
    chk("alu_after_pending", pending, 32'd0);

    // Load formatting
    load(5'd10, 32'h8070_F0A5, LOAD_LB,  2'd1, 32'hFFFF_FFF0);
    load(5'd11, 32'h8070_F0A5, LOAD_LBU, 2'd1, 32'h0000_00F0);
    load(5'd12, 32'h8070_F0A5, LOAD_LH,  2'd2, 32'hFFFF_8070);
    load(5'd13, 32'h8070_F0A5, LOAD_LHU, 2'd2, 32'h0000_8070);
    load(5'd14, 32'h8070_F0A5, LOAD_LW,  2'd1, 32'h8070_F0A5);
    load(5'd15, 32'h8070_F0A5, LOAD_LH,  2'd3, 32'hFFFF_8070);
    load(5'd16, 32'h1234_5678, 3'b111,   2'd0, 32'h1234_5678);
    idle(); idle();

    // Same-cycle mem+ALU to x3, then fill to DEPTH; ALU stalls when full
    step(1'b1, 5'd3,  32'h0000_00AA, LOAD_LW, 2'd0, 32'h0000_00AA, 1'b1, 5'd3,  32'h0000_00BB);
    step(1'b1, 5'd8,  32'h0000_0108, LOAD_LW, 2'd0, 32'h0000_0108, 1'b1, 5'd9,  32'h0000_0109);
    step(1'b1, 5'd10, 32'h0000_010A, LOAD_LW, 2'd0, 32'h0000_010A, 1'b1, 5'd11, 32'h0000_010B);
    chk("full_pending", pending, 32'h0000_0F00);
    step(1'b1, 5'd12, 32'h0000_010C, LOAD_LW, 2'd0, 32'h0000_010C, 1'b1, 5'd13, 32'h0000_010D);
    alu(5'd13, 32'h0000_010D);
    idle(); idle(); idle(); idle(); idle();
    chk("fill_drained", 32'(sb.size()), 32'd0);

    // x0 destination: handshake but no write
    alu(5'd0, 32'h0000_1234);
    chk("x0_reg_write", 32'(reg_write), 32'd0);
    chk("x0_pending", pending, 32'd0);
    idle();

`ifdef WB_FWD_EN
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    step(1'b1, 5'd7, 32'h1, LOAD_LW, 2'd0, 32'h1, 1'b1, 5'd7, 32'h2);
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_data1", fwd_data1, 32'h2);
    chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
    chk("fwd_data2", fwd_data2, 32'd0);
    idle(); idle();
    chk("fwd_empty_hit1", 32'(fwd_hit1), 32'd0);
`endif

    idle(); idle();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_pending", pending, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
